bcd_gray_arb: RTL
=================

BCD_GRAY_ARB -- requirements
Module: bcd_gray_arb

Interface
REQ-001 Parameter CNT_W, default 8: width of the completed-conversion counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid  input  1  requester 0 presents a BCD digit.
REQ-005 req0_bcd  input  4  requester 0 BCD digit.
REQ-006 req0_ready  output  1  requester 0 digit accepted this cycle.
REQ-007 req1_valid  input  1  requester 1 presents a BCD digit.
REQ-008 req1_bcd  input  4  requester 1 BCD digit.
REQ-009 req1_ready  output  1  requester 1 digit accepted this cycle.
REQ-010 out_valid  output  1  out_gray/out_src/out_err hold a result.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_gray  output  4  Gray code of the accepted digit.
REQ-013 out_src  output  1  index of the requester that supplied the digit.
REQ-014 out_err  output  1  accepted digit was not valid BCD (>9).
REQ-015 conv_count  output  CNT_W  number of results consumed, modulo 2^CNT_W.

Function
REQ-016 The block SHALL share one BCD-to-Gray conversion path between two requesters through a one-entry output register.
REQ-017 Conversion SHALL be gray[3]=bcd[3], gray[2]=bcd[3]^bcd[2], gray[1]=bcd[2]^bcd[1], gray[0]=bcd[1]^bcd[0].
REQ-018 The state machine SHALL have two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-019 A digit SHALL be accepted when state is EMPTY, or FULL with out_ready=1 in the same cycle (drain and refill, no bubble).
REQ-020 At most one requester SHALL be accepted per cycle; readyN SHALL be 1 only for the granted requester in an accept cycle, and readyN SHALL be combinational from valids, state and out_ready.
REQ-021 Arbitration SHALL be round-robin: with both valid, grant goes to the requester not granted last; with one valid, that one is granted.
REQ-022 The last-grant pointer SHALL update only on an accept.
REQ-023 Latency: a digit accepted in cycle N SHALL appear on out_gray/out_src/out_err with out_valid=1 in cycle N+1.
REQ-024 While FULL and out_ready=0, out_gray, out_src and out_err SHALL be held stable and both readys SHALL be 0.
REQ-025 FULL with out_ready=1 and no requester valid SHALL transition to EMPTY.
REQ-026 conv_count SHALL increment by 1 on every cycle with out_valid=1 and out_ready=1, wrapping from 2^CNT_W-1 to 0.
REQ-027 A requester's valid and data SHALL be ignored whenever its ready is 0; no requester input SHALL be buffered other than in the output register.

Reset
REQ-028 Assertion of rst_n=0 SHALL, without waiting for clk, force state EMPTY, out_valid=0, out_gray=0, out_src=0, out_err=0, conv_count=0, and the last-grant pointer to requester 1 (requester 0 wins the first contention).
REQ-029 A result held in the output register when reset asserts SHALL be discarded and not counted.
REQ-030 After rst_n deasserts, the first accept SHALL be possible on the first rising clk edge.

Configuration
REQ-031 Macro BCD_GRAY_ARB_CHECK_EN: when defined, out_err SHALL be registered as 1 for an accepted digit with value 10..15, otherwise 0; conversion of such digits SHALL still occur.
REQ-032 Without BCD_GRAY_ARB_CHECK_EN, out_err SHALL be constant 0 and no range-check logic SHALL be present.

Verification
REQ-033 req0 bcd=0101, out_ready=1 -> next cycle out_valid=1, out_gray=0111, out_src=0, out_err=0; conv_count 0->1.
REQ-034 Both requesters continuously valid (req0=1001, req1=0011), out_ready=1 -> grants alternate 0,1,0,1; out_gray alternates 1101, 0010; one result per cycle.
REQ-035 out_ready=0 for 3 cycles with result 0111 held -> out_gray stable, req0_ready=req1_ready=0, conv_count unchanged; out_ready=1 -> drained and refilled same cycle.
REQ-036 With BCD_GRAY_ARB_CHECK_EN: req1 bcd=1100 -> out_gray=1010, out_err=1, out_src=1; without macro -> out_gray=1010, out_err=0.
REQ-037 CNT_W=8, drive 256 consumed results -> conv_count wraps 255->0.
REQ-038 rst_n pulsed low mid-transfer while FULL -> out_valid=0 immediately, conv_count=0; with both requesters then valid, first grant goes to requester 0.

Source files
------------

// File: rtl/bcd_gray_arb.sv
// bcd_gray_arb
//   Two requesters share one BCD-to-Gray converter. The converted digit sits
//   in a one-entry output register until the consumer takes it. A round-robin
//   pointer decides between the requesters when both present a digit. The
//   register is refilled in the same cycle it drains, so there is no bubble.
//
// Parameters
//   CNT_W       width of the consumed-result counter (conv_count)
//
// Ports
//   clk, rst_n          clock; asynchronous active-low reset
//   reqN_valid/_bcd     requester N presents a 4-bit BCD digit
//   reqN_ready          requester N's digit is taken this cycle (combinational)
//   out_valid/out_ready result handshake toward the consumer
//   out_gray            Gray code of the held digit
//   out_src             requester index that supplied the held digit
//   out_err             held digit was outside 0..9 (only with the check build)
//   conv_count          results consumed, modulo 2^CNT_W
//
// Build option
//   BCD_GRAY_ARB_CHECK_EN  when defined, out_err flags digits 10..15;
//                          otherwise out_err is tied to 0 and no range check
//                          exists.
module bcd_gray_arb #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [3:0]       req0_bcd,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [3:0]       req1_bcd,
  output logic             req1_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_gray,
  output logic             out_src,
  output logic             out_err,
  output logic [CNT_W-1:0] conv_count
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  function automatic logic [3:0] bcd2gray(input logic [3:0] b);
    return {b[3], b[3] ^ b[2], b[2] ^ b[1], b[1] ^ b[0]};
  endfunction

  logic [0:0]       state_p1;
  logic             last_p1;
  logic [3:0]       gray_p1;
  logic             src_p1;
  logic [CNT_W-1:0] cnt_p1;

  logic       can_load;
  logic       sel;
  logic       accept;
  logic       drain;
  logic [3:0] bcd_sel;

  // Stage 0: arbitration and conversion, all combinational
  always_comb begin
    can_load = (state_p1 == EMPTY) || out_ready;
    // With both valid the requester not served last wins; otherwise the
    // single valid one wins (sel = req1_valid also covers "none valid").
    sel      = (req0_valid && req1_valid) ? ~last_p1 : req1_valid;
    accept   = can_load && (req0_valid || req1_valid);
    drain    = (state_p1 == FULL) && out_ready;
    bcd_sel  = sel ? req1_bcd : req0_bcd;
  end

  assign req0_ready = accept && !sel;
  assign req1_ready = accept && sel;

  // Stage 1: output register, grant pointer and consumed counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1 <= EMPTY;
      last_p1  <= 1'b1;
      gray_p1  <= 4'd0;
      src_p1   <= 1'b0;
    end else if (accept) begin
      state_p1 <= FULL;
      last_p1  <= sel;
      gray_p1  <= bcd2gray(bcd_sel);
      src_p1   <= sel;
    end else if (drain) begin
      state_p1 <= EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p1 <= '0;
    end else if (drain) begin
      cnt_p1 <= cnt_p1 + CNT_W'(1);
    end
  end

`ifdef BCD_GRAY_ARB_CHECK_EN
  function automatic logic bcd_invalid(input logic [3:0] b);
    return b > 4'd9;
  endfunction

  logic err_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_p1 <= 1'b0;
    end else if (accept) begin
      err_p1 <= bcd_invalid(bcd_sel);
    end
  end

  assign out_err = err_p1;
`else
  assign out_err = 1'b0;
`endif

  assign out_valid  = (state_p1 == FULL);
  assign out_gray   = gray_p1;
  assign out_src    = src_p1;
  assign conv_count = cnt_p1;

endmodule
